// File: rtl/icache_assoc.sv
// Set-associative, multi-word-block, read-only instruction cache between the
// fetch port and the memory instruction channel; invalid-first/round-robin fill.
module icache_assoc #(
  parameter int unsigned SETS  = 8,
  parameter int unsigned WAYS  = 2,
  parameter int unsigned WORDS = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        flush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int unsigned S  = $clog2(SETS);
  localparam int unsigned W  = $clog2(WORDS);
  localparam int unsigned TW = 32 - S - W - 2;
  localparam int unsigned CW = (W > 0) ? W : 1;
  localparam int unsigned PW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {LOOKUP, FILL} state_t;
  state_t state, state_next;

  logic [TW-1:0] req_tag;
  logic [S-1:0]  req_idx;
  logic [CW-1:0] req_word;
  logic [1:0]    unused_byte_bits;

  assign req_tag          = imemaddr[31:S+W+2];
  assign req_idx          = imemaddr[S+W+1:W+2];
  assign unused_byte_bits = imemaddr[1:0];

  generate
    if (W > 0) begin : g_word
      assign req_word = imemaddr[W+1:2];
    end else begin : g_noword
      assign req_word = '0;
    end
  endgenerate

  logic [SETS-1:0] valid [WAYS];
  logic [TW-1:0]   tags  [WAYS][SETS];
  logic [31:0]     data  [WAYS][SETS][WORDS];
  logic [PW-1:0]   vptr  [SETS];

  logic [TW-1:0] fill_tag;
  logic [S-1:0]  fill_idx;
  logic [CW-1:0] cnt;
  logic [31:0]   buffer [WORDS];

  logic [WAYS-1:0] match;
  logic [31:0]     hit_word;
  logic            lookup_hit;
  logic [PW-1:0]   victim;
  logic            from_ptr;
  logic            fill_done;

  always_comb begin
    match    = '0;
    hit_word = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid[w][req_idx] && tags[w][req_idx] == req_tag) begin
        match[w] = 1'b1;
        hit_word = data[w][req_idx][req_word];
      end
    end
  end

  assign lookup_hit = |match;

  // Lowest-numbered invalid way wins; the round-robin pointer is only a fallback.
  always_comb begin
    victim   = vptr[fill_idx];
    from_ptr = 1'b1;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (from_ptr && !valid[w][fill_idx]) begin
        victim   = PW'(w);
        from_ptr = 1'b0;
      end
    end
  end

  assign fill_done = (state == FILL) && !iwait && !flush && (cnt == CW'(WORDS - 1));

  always_comb begin
    state_next = state;
    ihit       = 1'b0;
    imemload   = '0;
    iREN       = 1'b0;
    iaddr      = '0;
    unique case (state)
      LOOKUP: begin
        ihit = imemREN && lookup_hit && !flush && !RST;
        if (ihit) imemload = hit_word;
        if (imemREN && !lookup_hit && !flush) state_next = FILL;
      end
      FILL: begin
        if (!RST) begin
          iREN  = 1'b1;
          iaddr = {fill_tag, fill_idx, {(W + 2){1'b0}}} | (32'(cnt) << 2);
        end
        if (flush || fill_done) state_next = LOOKUP;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= LOOKUP;
      cnt      <= '0;
      fill_tag <= '0;
      fill_idx <= '0;
      for (int unsigned w = 0; w < WAYS; w++) valid[w] <= '0;
      for (int unsigned s = 0; s < SETS; s++) vptr[s] <= '0;
      for (int unsigned k = 0; k < WORDS; k++) buffer[k] <= '0;
    end else begin
      state <= state_next;
      if (flush) begin
        for (int unsigned w = 0; w < WAYS; w++) valid[w] <= '0;
        for (int unsigned s = 0; s < SETS; s++) vptr[s] <= '0;
      end else begin
        if (state == LOOKUP && imemREN && !lookup_hit) begin
          fill_tag <= req_tag;
          fill_idx <= req_idx;
          cnt      <= '0;
        end
        if (state == FILL && !iwait) begin
          buffer[cnt] <= iload;
          cnt         <= cnt + CW'(1);
        end
        if (fill_done) begin
          valid[victim][fill_idx] <= 1'b1;
          if (from_ptr && WAYS > 1) vptr[fill_idx] <= vptr[fill_idx] + PW'(1);
        end
      end
    end
  end

  // Tag/data arrays carry no reset; the final beat bypasses the buffer.
  always_ff @(posedge CLK) begin
    if (!RST && fill_done) begin
      tags[victim][fill_idx] <= fill_tag;
      for (int unsigned k = 0; k + 1 < WORDS; k++) data[victim][fill_idx][k] <= buffer[k];
      data[victim][fill_idx][WORDS-1] <= iload;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && state == LOOKUP && imemREN) assert ($countones(match) <= 1);
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc: a default instance and a 4x4x4 instance, each checked
// every cycle against a line-level behavioural model plus directed scenarios.
module tb_icache_assoc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, fl, wt;
  logic        ren  [2];
  logic [31:0] addr [2];
  logic        ihit0, ihit1, iren0, iren1;
  logic [31:0] load0, load1, iaddr0, iaddr1, iload0, iload1;

  int unsigned total = 0;
  int unsigned bad   = 0;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    if (a == 32'h40) return 32'hAAAA0000;
    if (a == 32'h44) return 32'hBBBB1111;
    return {a[15:0] ^ 16'h5A3C, a[15:0] + 16'h1357};
  endfunction

  assign iload0 = mem_word(iaddr0);
  assign iload1 = mem_word(iaddr1);

  icache_assoc u0 (
    .CLK(clk), .RST(rst), .imemREN(ren[0]), .imemaddr(addr[0]), .flush(fl),
    .ihit(ihit0), .imemload(load0), .iREN(iren0), .iaddr(iaddr0),
    .iwait(wt), .iload(iload0)
  );

  icache_assoc #(.SETS(4), .WAYS(4), .WORDS(4)) u1 (
    .CLK(clk), .RST(rst), .imemREN(ren[1]), .imemaddr(addr[1]), .flush(fl),
    .ihit(ihit1), .imemload(load1), .iREN(iren1), .iaddr(iaddr1),
    .iwait(wt), .iload(iload1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: each cache line remembered by the byte address of its first word.
  int unsigned c_sets  [2] = '{8, 4};
  int unsigned c_ways  [2] = '{2, 4};
  int unsigned c_words [2] = '{2, 4};
  bit          m_valid [2][8][4];
  int unsigned m_line  [2][8][4];
  int unsigned m_ptr   [2][8];
  bit          m_fill  [2];
  int unsigned m_base  [2];
  int unsigned m_cnt   [2];
  bit          s_hit   [2];
  logic [31:0] s_load  [2];
  bit          stall_mode = 1'b0;
  int unsigned stall_ctr  = 0;

  function automatic int unsigned line_of(int d, int unsigned a);
    return a - (a % (4 * c_words[d]));
  endfunction

  function automatic int unsigned set_of(int d, int unsigned a);
    return (a / (4 * c_words[d])) % c_sets[d];
  endfunction

  function automatic bit m_lookup(int d, int unsigned a);
    int unsigned s = set_of(d, a);
    for (int w = 0; w < int'(c_ways[d]); w++)
      if (m_valid[d][s][w] && m_line[d][s][w] == line_of(d, a)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_clear(int d);
    for (int s = 0; s < 8; s++) begin
      m_ptr[d][s] = 0;
      for (int w = 0; w < 4; w++) m_valid[d][s][w] = 1'b0;
    end
  endtask

  task automatic m_install(int d);
    int unsigned s = set_of(d, m_base[d]);
    int v = -1;
    for (int w = 0; w < int'(c_ways[d]); w++)
      if (v < 0 && !m_valid[d][s][w]) v = w;
    if (v < 0) begin
      v = int'(m_ptr[d][s]);
      m_ptr[d][s] = (m_ptr[d][s] + 1) % c_ways[d];
    end
    m_valid[d][s][v] = 1'b1;
    m_line[d][s][v]  = m_base[d];
  endtask

  // Entered and left at a falling edge; callers change inputs between calls.
  task automatic cycle();
    bit          e_hit, e_ren;
    logic [31:0] e_load, e_addr;
    if (stall_mode && m_fill[0]) begin
      wt = (stall_ctr < 3);
      stall_ctr = (stall_ctr == 3) ? 0 : stall_ctr + 1;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      e_hit = 1'b0; e_ren = 1'b0; e_load = '0; e_addr = '0;
      if (!rst) begin
        if (!m_fill[d]) begin
          if (ren[d] && !fl && m_lookup(d, addr[d])) begin
            e_hit  = 1'b1;
            e_load = mem_word(addr[d] & ~32'h3);
          end
        end else begin
          e_ren  = 1'b1;
          e_addr = m_base[d] + 4 * m_cnt[d];
        end
      end
      s_hit[d]  = (d == 0) ? ihit0 : ihit1;
      s_load[d] = (d == 0) ? load0 : load1;
      check($sformatf("ihit%0d", d), 32'(s_hit[d]), 32'(e_hit));
      check($sformatf("imemload%0d", d), s_load[d], e_load);
      check($sformatf("iREN%0d", d), (d == 0) ? 32'(iren0) : 32'(iren1), 32'(e_ren));
      check($sformatf("iaddr%0d", d), (d == 0) ? iaddr0 : iaddr1, e_addr);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst || fl) begin
        m_clear(d);
        m_fill[d] = 1'b0;
      end else if (!m_fill[d]) begin
        if (ren[d] && !m_lookup(d, addr[d])) begin
          m_fill[d] = 1'b1;
          m_base[d] = line_of(d, addr[d]);
          m_cnt[d]  = 0;
        end
      end else if (!wt) begin
        m_cnt[d]++;
        if (m_cnt[d] == c_words[d]) begin
          m_install(d);
          m_fill[d] = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  // Holds the fetch until a hit is seen; lat = cycles before the hit cycle.
  task automatic fetch(input int d, input logic [31:0] a, output int lat);
    lat = -1;
    ren[d]  = 1'b1;
    addr[d] = a;
    for (int n = 0; n < 60; n++) begin
      cycle();
      if (s_hit[d]) begin
        lat = n;
        break;
      end
    end
    ren[d] = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  int lat;

  initial begin
    rst = 1'b1; fl = 1'b0; wt = 1'b0;
    ren[0] = 1'b0; ren[1] = 1'b0; addr[0] = '0; addr[1] = '0;
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;

    fetch(0, 32'h44, lat);
    check("cold_lat", 32'(lat), 32'd3);
    check("cold_word", s_load[0], 32'hBBBB1111);
    fetch(0, 32'h40, lat);
    check("warm_lat", 32'(lat), 32'd0);
    check("warm_word", s_load[0], 32'hAAAA0000);

    pulse_reset();
    stall_mode = 1'b1; stall_ctr = 0;
    fetch(0, 32'h44, lat);
    check("stall_lat", 32'(lat), 32'd9);
    stall_mode = 1'b0; wt = 1'b0;

    pulse_reset();
    fetch(0, 32'h40, lat); check("repl_t1", 32'(lat), 32'd3);
    fetch(0, 32'h80, lat); check("repl_t2", 32'(lat), 32'd3);
    fetch(0, 32'hC0, lat); check("repl_t3", 32'(lat), 32'd3);
    fetch(0, 32'h80, lat); check("repl_keep", 32'(lat), 32'd0);
    fetch(0, 32'h40, lat); check("repl_evict", 32'(lat), 32'd3);

    pulse_reset();
    fetch(0, 32'h40, lat);
    fetch(0, 32'h80, lat);
    fl = 1'b1; cycle(); fl = 1'b0;
    fetch(0, 32'h40, lat); check("flush_miss_a", 32'(lat), 32'd3);
    fetch(0, 32'h80, lat); check("flush_miss_b", 32'(lat), 32'd3);

    ren[0] = 1'b1; addr[0] = 32'h100;
    cycle();
    cycle();
    fl = 1'b1; ren[0] = 1'b0;
    cycle();
    fl = 1'b0;
    cycle();
    check("flush_iren", 32'(iren0), 32'd0);
    fetch(0, 32'h100, lat); check("flush_novalid", 32'(lat), 32'd3);

    for (int i = 0; i < 20; i++) begin
      addr[0] = $urandom;
      cycle();
      check("idle_hit", 32'(ihit0), 32'd0);
      check("idle_iren", 32'(iren0), 32'd0);
    end

    ren[0] = 1'b1; addr[0] = 32'h204;
    cycle();
    ren[0] = 1'b0; addr[0] = 32'h3F0;
    repeat (4) cycle();
    fetch(0, 32'h204, lat); check("renlow_fill", 32'(lat), 32'd0);

    ren[0] = 1'b1; addr[0] = 32'h300;
    cycle();
    cycle();
    rst = 1'b1; ren[0] = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();
    check("rst_iren", 32'(iren0), 32'd0);
    fetch(0, 32'h300, lat); check("rst_novalid", 32'(lat), 32'd3);

    fetch(1, 32'h44, lat);
    check("big_cold_lat", 32'(lat), 32'd5);
    check("big_cold_word", s_load[1], 32'hBBBB1111);
    fetch(1, 32'h4C, lat);
    check("big_word3_lat", 32'(lat), 32'd0);
    check("big_word3", s_load[1], mem_word(32'h4C));
    fetch(1, 32'h54, lat); check("big_set1_lat", 32'(lat), 32'd5);
    fetch(1, 32'h48, lat); check("big_set0_keep", 32'(lat), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      fl  = ($urandom_range(0, 39) == 0);
      wt  = ($urandom_range(0, 2) == 0);
      for (int d = 0; d < 2; d++) begin
        ren[d]  = ($urandom_range(0, 4) != 0);
        addr[d] = (32'($urandom_range(0, 5)) << 7) | (32'($urandom_range(0, 31)) << 2)
                | 32'($urandom_range(0, 3));
      end
      cycle();
    end

    rst = 1'b0; fl = 1'b0; wt = 1'b0; ren[0] = 1'b0; ren[1] = 1'b0;
    cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
- Parametrised, set-associative, multi-word-block instruction cache; successor to the single-word direct-mapped icache.
- Sits between the datapath fetch port and the memory controller's instruction channel.
- Adds configurable sets, ways and words per block, invalid-first/round-robin replacement, and a one-cycle flush.

Parameters:
- SETS, 8, number of sets; power of 2, ≥2.
- WAYS, 2, associativity; one of 1, 2, 4.
- WORDS, 2, 32-bit words per block; power of 2, ≥1.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- imemREN  input  1  datapath fetch request.
- imemaddr  input  32  datapath byte address; bits [1:0] ignored.
- flush  input  1  invalidate every line.
- ihit  output  1  fetch served this cycle.
- imemload  output  32  instruction word; valid when ihit=1.
- iREN  output  1  memory read request.
- iaddr  output  32  memory word address; bits [1:0]=0.
- iwait  input  1  memory busy; read data valid when iREN=1 and iwait=0.
- iload  input  32  memory read data.

Behaviour:
Address split (W=log2 WORDS, S=log2 SETS):
- [1:0] byte offset.
- [W+1:2] word offset.
- [S+W+1:W+2] index.
- [31:S+W+2] tag.

Storage:
- Per way and set: valid bit, tag, and WORDS data words.
- Per set: victim pointer, log2(WAYS) bits, absent when WAYS=1.

Reset (RST=1 at a rising edge):
- All valid bits, victim pointers, fill counter and fill buffer cleared.
- State becomes LOOKUP.
- While in reset: ihit=0, imemload=0, iREN=0, iaddr=0.
- Reset mid-FILL abandons the fill; no line is written.

State LOOKUP:
- ihit is combinational: imemREN & (some way at index is valid with matching tag).
- On hit: imemload = that way's word at the word offset; no state change.
- Only one way may match. Matching ways are impossible by construction; this is a verification assertion.
- Miss with imemREN=1 and flush=0: latch the tag and index of imemaddr, counter=0, next state FILL.
- imemREN=0: ihit=0, imemload=0, stay in LOOKUP.
- iREN=0 in LOOKUP.

State FILL:
- iREN=1; iaddr = {latched tag, latched index, counter, 2'b00}.
- Fill always starts at word 0 of the block.
- Each cycle with iwait=0: buffer[counter] <= iload, counter increments.
- On the beat with counter=WORDS-1 and iwait=0, choose the victim way:
  - the lowest-numbered invalid way at the index, if one exists;
  - otherwise the set's victim pointer.
- Write tag, valid=1 and all buffered words (including the current beat) into the victim way.
- If the victim came from the pointer, the pointer increments modulo WAYS. A fill into an invalid way leaves the pointer unchanged.
- Next state LOOKUP. The originating fetch hits on the following cycle.
- ihit=0 and imemload=0 throughout FILL.
- Deasserting imemREN or changing imemaddr during FILL does not abort the fill; it completes to the latched block.

Flush:
- flush=1 at an edge clears all valid bits and all victim pointers.
- ihit is forced to 0 in that cycle.
- A flush in FILL abandons the fill; next state LOOKUP; iREN drops on the next cycle.
- If reset and flush are both asserted, reset dominates; the result is identical.

Latency:
- Miss to hit = 1 (LOOKUP) + sum over WORDS beats of (wait cycles + 1) + 0 (hit in the returning LOOKUP cycle).
- With zero-wait memory and WORDS=2: the miss in cycle 0 is served as a hit in cycle 3.

Hit-time structure:
- No write port toward memory. The cache is read-only.
- Data updates only on a completed fill.

Test Plan:
- Cold miss, defaults (SETS=8, WAYS=2, WORDS=2), iwait=0, addr 0x0000_0044 (idx 0, tag 1, word 1), memory words 0x40→0xAAAA0000 and 0x44→0xBBBB1111:
  - iaddr sequence is 0x40 then 0x44;
  - ihit=1 with imemload=0xBBBB1111 in cycle 3;
  - addr 0x40 then hits immediately with 0xAAAA0000.
- Memory stall, iwait held high 3 cycles per beat on the same miss:
  - iaddr is held stable while iwait=1;
  - ihit is first seen 9 cycles after the miss cycle.
- Associativity and replacement in set 0:
  - fill tags 1 (0x40), 2 (0x80) and 3 (0xC0) in sequence;
  - tags 1 and 2 land in ways 0 and 1, pointer still 0;
  - tag 3 replaces way 0 and the pointer becomes 1;
  - 0x80 hits and 0x40 misses.
- Flush:
  - after filling 0x40 and 0x80, pulse flush for 1 cycle;
  - both addresses then miss;
  - flush asserted mid-FILL drops iREN the next cycle and no line becomes valid.
- imemREN low: imemREN=0 with any address gives ihit=0 and iREN=0 indefinitely. imemREN deasserted mid-FILL: the fill still completes and a later fetch of the same address hits.
- Synchronous reset: RST asserted during FILL beat 1 means no line becomes valid and iREN=0 the cycle after. Rerun the cold-miss test with SETS=4, WAYS=4, WORDS=4 and check the address split and 4-beat fill.
